arm_control_unit: RTL and testbench

// - Control unit for the single-cycle ARM datapath: decodes Op/Funct/Rd of the current

---
 rtl/arm_control_unit_pkg.sv | 60 ++++++
 rtl/arm_control_unit_if.sv | 26 ++
 rtl/arm_control_unit_conditional_logic.sv | 37 +++
 rtl/arm_control_unit_decoder.sv | 80 ++++++++
 rtl/arm_control_unit.sv | 42 ++++
 tb/tb_arm_control_unit.sv | 180 ++++++++++++++++++
 6 files changed

// File: rtl/arm_control_unit_pkg.sv
// Shared encodings for the single-cycle ARM control unit: ALU ops, opcodes,
// data-processing commands, condition codes and extend selects.
package arm_control_unit_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NUL = 2'b11
  } op_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  // flags = {N,Z,C,V}
  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      C_EQ:    cond_ex = z;
      C_NE:    cond_ex = !z;
      C_CS:    cond_ex = c;
      C_CC:    cond_ex = !c;
      C_MI:    cond_ex = n;
      C_PL:    cond_ex = !n;
      C_VS:    cond_ex = v;
      C_VC:    cond_ex = !v;
      C_HI:    cond_ex = c & !z;
      C_LS:    cond_ex = !c | z;
      C_GE:    cond_ex = (n == v);
      C_LT:    cond_ex = (n != v);
      C_GT:    cond_ex = !z & (n == v);
      C_LE:    cond_ex = z | (n != v);
      C_AL:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_control_unit_if.sv
// Instruction-field inputs and datapath-control outputs of the ARM control unit.
interface arm_control_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [3:0] Rd;
  logic [5:0] Funct;
  logic [1:0] Op;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemToReg;
  logic       ALUSrc;

  modport master (
    output Cond, ALUFlags, Rd, Funct, Op,
    input  ImmSrc, RegSrc, ALUControl, PCSrc, RegWrite, MemWrite, MemToReg, ALUSrc
  );

  modport slave (
    input  Cond, ALUFlags, Rd, Funct, Op,
    output ImmSrc, RegSrc, ALUControl, PCSrc, RegWrite, MemWrite, MemToReg, ALUSrc
  );
endinterface

// File: rtl/arm_control_unit_conditional_logic.sv
// Stored NZCV flags, condition evaluation and gating of architectural writes.
module arm_control_unit_conditional_logic
  import arm_control_unit_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write
);
  logic [3:0] flags;
  logic       cex;
  logic [1:0] flag_write;

  assign cex        = cond_ex(cond, flags);
  assign flag_write = flag_w & {2{cex}};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      flags <= 4'b0000;
    end else begin
      if (flag_write[1]) flags[3:2] <= alu_flags[3:2];
      if (flag_write[0]) flags[1:0] <= alu_flags[1:0];
    end
  end

  assign pc_src    = pcs & cex;
  assign reg_write = reg_w & cex & !no_write;
  assign mem_write = mem_w & cex;
endmodule

// File: rtl/arm_control_unit_decoder.sv
// Main + ALU decode: Op/Funct/Rd to ungated datapath controls.
module arm_control_unit_decoder
  import arm_control_unit_pkg::*;
(
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       no_write,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);
  logic       branch, alu_op;
  logic [3:0] cmd;
  logic       s;

  assign cmd = funct[4:1];
  assign s   = funct[0];

  always_comb begin
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_8;
    reg_src    = 2'b00;
    alu_op     = 1'b0;
    case (op)
      OP_DP: begin
        reg_w   = 1'b1;
        alu_src = funct[5];
        alu_op  = 1'b1;
      end
      OP_MEM: begin
        alu_src = 1'b1;
        imm_src = IMM_12;
        if (funct[0]) begin
          reg_w      = 1'b1;
          mem_to_reg = 1'b1;
        end else begin
          mem_w   = 1'b1;
          reg_src = 2'b10;
        end
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_src = 1'b1;
        imm_src = IMM_24;
        reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin alu_control = ALU_ADD; flag_w = {s, s}; end
        CMD_SUB: begin alu_control = ALU_SUB; flag_w = {s, s}; end
        CMD_AND: begin alu_control = ALU_AND; flag_w = {s, 1'b0}; end
        CMD_ORR: begin alu_control = ALU_ORR; flag_w = {s, 1'b0}; end
        // compare exists only for its flags, so it sets them regardless of S
        CMD_CMP: begin alu_control = ALU_SUB; flag_w = 2'b11; no_write = 1'b1; end
        default: ;
      endcase
    end
  end

  assign pcs = ((rd == 4'hF) & reg_w) | branch;
endmodule

// File: rtl/arm_control_unit.sv
// Control unit for the single-cycle ARM datapath: decode plus condition-gated writes.
module arm_control_unit
  import arm_control_unit_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  arm_control_unit_if.slave bus
);
  logic       pcs, reg_w, mem_w, no_write;
  logic [1:0] flag_w;

  arm_control_unit_decoder u_dec (
    .op          (bus.Op),
    .funct       (bus.Funct),
    .rd          (bus.Rd),
    .pcs         (pcs),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .mem_to_reg  (bus.MemToReg),
    .alu_src     (bus.ALUSrc),
    .no_write    (no_write),
    .imm_src     (bus.ImmSrc),
    .reg_src     (bus.RegSrc),
    .alu_control (bus.ALUControl),
    .flag_w      (flag_w)
  );

  arm_control_unit_conditional_logic u_cl (
    .Clk       (Clk),
    .Reset     (Reset),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .pc_src    (bus.PCSrc),
    .reg_write (bus.RegWrite),
    .mem_write (bus.MemWrite)
  );
endmodule

// File: tb/tb_arm_control_unit.sv
// Directed bench for arm_control_unit with hand-computed expectations.
module tb_arm_control_unit;
  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   failed = 0;

  arm_control_unit_if bus ();

  arm_control_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic [3:0] cond, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] rd,
                       input logic [3:0] alu_flags);
    bus.Cond     = cond;
    bus.Op       = op;
    bus.Funct    = funct;
    bus.Rd       = rd;
    bus.ALUFlags = alu_flags;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Probe the stored flags through RegWrite of a plain AND (no flag write).
  task automatic probe(input string tag, input logic [3:0] cond, input logic exp);
    drive(cond, 2'b00, 6'b000000, 4'd5, 4'b0000);
    chk(tag, {3'b000, bus.RegWrite}, {3'b000, exp});
  endtask

  initial begin
    Reset = 1'b0;
    drive(4'h0, 2'b00, 6'b000000, 4'd5, 4'b0000);
    #4;
    chk("rst_regwrite_eq", {3'b000, bus.RegWrite}, 4'h0);
    chk("rst_pcsrc",       {3'b000, bus.PCSrc},    4'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // ANDS with immediate: flags 1100 latched (N,Z only)
    @(negedge Clk);
    drive(4'hE, 2'b00, 6'b100001, 4'd5, 4'b1100);
    chk("ands_aluctl",  {2'b00, bus.ALUControl}, 4'h2);
    chk("ands_alusrc",  {3'b000, bus.ALUSrc},    4'h1);
    chk("ands_regwr",   {3'b000, bus.RegWrite},  4'h1);
    chk("ands_immsrc",  {2'b00, bus.ImmSrc},     4'h0);
    tick();
    probe("ands_flag_eq", 4'h0, 1'b1);
    probe("ands_flag_mi", 4'h4, 1'b1);

    // AND without S: flags must stay 1100
    drive(4'hE, 2'b00, 6'b100000, 4'd5, 4'b0111);
    tick();
    probe("and_nos_eq", 4'h0, 1'b1);
    probe("and_nos_cs", 4'h2, 1'b0);
    probe("and_nos_vs", 4'h6, 1'b0);

    // ANDEQ after flags cleared
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    probe("andeq_z0", 4'h0, 1'b0);
    probe("ne_z0",    4'h1, 1'b1);

    // CMP: SUB, no register write, forced NZCV update
    drive(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0011);
    chk("cmp_aluctl", {2'b00, bus.ALUControl}, 4'h1);
    chk("cmp_regwr",  {3'b000, bus.RegWrite},  4'h0);
    tick();
    probe("cmp_cs", 4'h2, 1'b1);
    probe("cmp_vs", 4'h6, 1'b1);
    probe("cmp_eq", 4'h0, 1'b0);
    probe("cmp_ge", 4'hA, 1'b0);
    probe("cmp_lt", 4'hB, 1'b1);
    probe("cmp_hi", 4'h8, 1'b1);
    probe("cmp_le", 4'hD, 1'b1);
    probe("cmp_nv", 4'hF, 1'b0);

    // Failed condition (EQ with Z=0) must not touch flags
    drive(4'h0, 2'b00, 6'b010101, 4'd0, 4'b0100);
    tick();
    probe("nocond_cs", 4'h2, 1'b1);
    probe("nocond_eq", 4'h0, 1'b0);

    // Unsupported cmd with S=1: ADD encoding, no flag write
    drive(4'hE, 2'b00, 6'b000011, 4'd1, 4'b0100);
    chk("eor_aluctl", {2'b00, bus.ALUControl}, 4'h0);
    tick();
    probe("eor_eq", 4'h0, 1'b0);

    // SUBS: all four flags written
    drive(4'hE, 2'b00, 6'b000101, 4'd1, 4'b1000);
    chk("subs_aluctl", {2'b00, bus.ALUControl}, 4'h1);
    tick();
    probe("subs_mi", 4'h4, 1'b1);
    probe("subs_cs", 4'h2, 1'b0);
    probe("subs_gt", 4'hC, 1'b0);

    // ORR with register operand
    drive(4'hE, 2'b00, 6'b011000, 4'd2, 4'b0000);
    chk("orr_aluctl", {2'b00, bus.ALUControl}, 4'h3);
    chk("orr_alusrc", {3'b000, bus.ALUSrc},    4'h0);

    // STR
    drive(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
    chk("str_memwr",  {3'b000, bus.MemWrite}, 4'h1);
    chk("str_immsrc", {2'b00, bus.ImmSrc},    4'h1);
    chk("str_regsrc", {2'b00, bus.RegSrc},    4'h2);
    chk("str_regwr",  {3'b000, bus.RegWrite}, 4'h0);
    chk("str_aluctl", {2'b00, bus.ALUControl}, 4'h0);

    // LDR
    drive(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000);
    chk("ldr_regwr",  {3'b000, bus.RegWrite}, 4'h1);
    chk("ldr_m2r",    {3'b000, bus.MemToReg}, 4'h1);
    chk("ldr_memwr",  {3'b000, bus.MemWrite}, 4'h0);
    chk("ldr_regsrc", {2'b00, bus.RegSrc},    4'h0);

    // STRNE with Z=0 executes, STREQ does not
    drive(4'h1, 2'b01, 6'b011000, 4'd3, 4'b0000);
    chk("strne_memwr", {3'b000, bus.MemWrite}, 4'h1);
    drive(4'h0, 2'b01, 6'b011000, 4'd3, 4'b0000);
    chk("streq_memwr", {3'b000, bus.MemWrite}, 4'h0);

    // Branch
    drive(4'hE, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("b_pcsrc",  {3'b000, bus.PCSrc},    4'h1);
    chk("b_immsrc", {2'b00, bus.ImmSrc},    4'h2);
    chk("b_regsrc", {2'b00, bus.RegSrc},    4'h1);
    chk("b_regwr",  {3'b000, bus.RegWrite}, 4'h0);
    drive(4'hF, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("bnv_pcsrc", {3'b000, bus.PCSrc}, 4'h0);

    // ADD to R15
    drive(4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000);
    chk("addpc_pcsrc", {3'b000, bus.PCSrc},    4'h1);
    chk("addpc_regwr", {3'b000, bus.RegWrite}, 4'h1);
    chk("addpc_aluctl", {2'b00, bus.ALUControl}, 4'h0);

    // Op=11: everything off
    drive(4'hE, 2'b11, 6'b111111, 4'hF, 4'b0000);
    chk("op3_ctl", {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.MemToReg}, 4'h0);
    chk("op3_src", {bus.ALUSrc, 1'b0, bus.ALUControl}, 4'h0);

    // Asynchronous reset mid-cycle clears flags (N was 1)
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    probe("async_rst_mi", 4'h4, 1'b0);
    probe("async_rst_pl", 4'h5, 1'b1);
    // Reset wins over a concurrent flag write
    drive(4'hE, 2'b00, 6'b000101, 4'd1, 4'b1111);
    tick();
    probe("rst_prio_eq", 4'h0, 1'b0);
    Reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
